ex_mem_skid_stage: RTL and testbench

Parametrised EX/MEM pipeline stage with valid/ready flow control, a one-entry skid buffer, synchronous flush, and a saturating backpressure counter. It sits between the execute and memory stages of the pipelined LEGv8 core. It supersedes the plain free-running EX/MEM register with one that can stall, insert bubbles, and absorb one cycle of downstream backpressure without dropping an instruction. Payload and control fields are carried as packed vectors so the same block can be reused at other stage boundaries.

---
 rtl/ex_mem_skid_stage.sv | 113 +++++++++++
 tb/tb_ex_mem_skid_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_skid_stage.sv
// EX/MEM pipeline stage: valid/ready handshake with a one-entry skid buffer,
// synchronous flush, gated control outputs and a saturating stall counter.
module ex_mem_skid_stage #(
  parameter int DATA_W = 198,
  parameter int CTRL_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // State encoding mirrors {skid_valid, main_valid}
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              main_valid, skid_valid;
  logic              accept, consume;
  logic              load_in_main, load_in_skid, load_skid_main;

  assign main_valid = (state != EMPTY);
  assign skid_valid = (state == FULL);
  assign in_ready   = !skid_valid;
  assign accept     = in_valid && in_ready;
  assign consume    = main_valid && out_ready;

  assign out_valid  = main_valid;
  assign out_data   = main_data;
  assign out_ctrl   = main_valid ? main_ctrl : '0;
  assign occupancy  = {skid_valid, main_valid && !skid_valid};

  always_comb begin
    state_n        = state;
    load_in_main   = 1'b0;
    load_in_skid   = 1'b0;
    load_skid_main = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          load_in_main = 1'b1;
          state_n      = ONE;
        end
      end
      ONE: begin
        if (accept && consume) begin
          load_in_main = 1'b1;
        end else if (accept) begin
          load_in_skid = 1'b1;
          state_n      = FULL;
        end else if (consume) begin
          state_n      = EMPTY;
        end
      end
      FULL: begin
        if (consume) begin
          load_skid_main = 1'b1;
          state_n        = ONE;
        end
      end
      default: state_n = EMPTY;
    endcase
    // Data registers may still load on flush; only the valid state matters.
    if (flush) state_n = EMPTY;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      state <= state_n;
      if (load_in_main) begin
        main_data <= in_data;
        main_ctrl <= in_ctrl;
      end else if (load_skid_main) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end
      if (load_in_skid) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end
    end
  end

  // Counts through flush; only reset clears it.
  always_ff @(posedge clock) begin
    if (reset)
      stall_cnt <= '0;
    else if (main_valid && !out_ready && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Bench for ex_mem_skid_stage: queue-based reference model checked every cycle
// plus hand-computed expectations for the directed scenarios.
module tb_ex_mem_skid_stage;
  localparam int DW = 198;
  localparam int CW = 5;

  logic          clock = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;
  logic [15:0]   stall_cnt;
  logic          in_ready2, out_valid2;
  logic [DW-1:0] out_data2;
  logic [CW-1:0] out_ctrl2;
  logic [1:0]    occupancy2;
  logic [1:0]    stall_cnt2;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  always #5 clock = ~clock;

  ex_mem_skid_stage dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  ex_mem_skid_stage #(.CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_ctrl(out_ctrl2),
    .occupancy(occupancy2), .stall_cnt(stall_cnt2)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk(logic [63:0] a);
    return {a + 64'd100, a, ~a, (a == 64'd0), a[4:0]};
  endfunction

  // Reference model: an ordered queue of at most two entries.
  logic [DW+CW-1:0] q[$];
  int unsigned      m_cnt, m_cnt2;

  always @(posedge clock) begin
    bit acc, con;
    acc = in_valid && (q.size() < 2);
    con = (q.size() > 0) && out_ready;
    if (reset) begin
      q.delete();
      m_cnt  = 0;
      m_cnt2 = 0;
    end else begin
      if (q.size() > 0 && !out_ready) begin
        if (m_cnt  < 65535) m_cnt++;
        if (m_cnt2 < 3)     m_cnt2++;
      end
      if (flush) q.delete();
      else begin
        if (con) void'(q.pop_front());
        if (acc) q.push_back({in_data, in_ctrl});
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      logic [DW+CW-1:0] f;
      chk("m_out_valid", out_valid, q.size() > 0);
      chk("m_in_ready", in_ready, q.size() < 2);
      chk("m_occupancy", occupancy, q.size());
      chk("m_stall_cnt", stall_cnt, m_cnt);
      chk("m_stall_cnt2", stall_cnt2, m_cnt2);
      if (q.size() > 0) begin
        f = q[0];
        chk("m_out_ctrl", out_ctrl, f[CW-1:0]);
        chk("m_out_alu", out_data[133:70], f[CW+133:CW+70]);
        chk("m_out_data_hi", out_data[197:134], f[CW+197:CW+134]);
        chk("m_out_data_lo", out_data[69:0], f[CW+69:CW]);
      end else begin
        chk("m_out_ctrl_bubble", out_ctrl, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic drive(bit v, bit rdy, logic [63:0] alu, logic [CW-1:0] c);
    in_valid  = v;
    out_ready = rdy;
    in_data   = mk(alu);
    in_ctrl   = c;
  endtask

  task automatic chk_reset_state(string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data[63:0], 0);
    chk({tag, "_out_data_alu"}, out_data[133:70], 0);
    chk({tag, "_out_ctrl"}, out_ctrl, 0);
    chk({tag, "_occupancy"}, occupancy, 0);
    chk({tag, "_stall_cnt"}, stall_cnt, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    reset = 1; flush = 0;
    drive(1, 0, 64'd7, 5'b11111);
    tick(); tick();
    chk_reset_state("rst");
    reset = 0;
    chk_en = 1;

    // Bubble gating
    drive(0, 0, 64'd9, 5'b11111);
    tick(); tick();
    chk("bubble_out_valid", out_valid, 0);
    chk("bubble_out_ctrl", out_ctrl, 0);

    // Streaming 1..10
    for (int k = 1; k <= 10; k++) begin
      drive(1, 1, k, CW'(k));
      tick();
      chk("stream_alu", out_data[133:70], k);
      chk("stream_occ", occupancy, 1);
      chk("stream_in_ready", in_ready, 1);
    end
    drive(0, 1, 64'd0, 5'b0);
    tick();
    chk("stream_drain_occ", occupancy, 0);

    // Skid: A in main, B arrives during one cycle of backpressure
    drive(1, 1, 64'd20, 5'b00110);
    tick();
    drive(1, 0, 64'd21, 5'b00110);
    tick();
    chk("skid_occ", occupancy, 2);
    chk("skid_in_ready", in_ready, 0);
    chk("skid_head", out_data[133:70], 20);
    chk("skid_stall", stall_cnt, 1);
    drive(0, 1, 64'd0, 5'b0);
    tick();
    chk("skid_b", out_data[133:70], 21);
    chk("skid_ready_back", in_ready, 1);
    tick();
    chk("skid_empty", occupancy, 0);

    // Reset while FULL
    drive(1, 1, 64'd30, 5'b00100);
    tick();
    drive(1, 0, 64'd31, 5'b00100);
    tick();
    chk("prerst_occ", occupancy, 2);
    reset = 1;
    tick();
    chk_reset_state("midrst");
    reset = 0;

    // Long stall with two entries held: 5 cycles of out_ready=0
    drive(1, 1, 64'd40, 5'b00110);
    tick();
    drive(1, 0, 64'd41, 5'b00110);
    tick();
    drive(1, 0, 64'd42, 5'b00110);
    for (int i = 0; i < 4; i++) tick();
    chk("stall_frozen", out_data[133:70], 40);
    chk("stall_occ", occupancy, 2);
    chk("stall_cnt5", stall_cnt, 5);
    chk("stall_sat3", stall_cnt2, 3);
    tick();
    chk("stall_cnt6", stall_cnt, 6);
    chk("stall_sat_hold", stall_cnt2, 3);

    // Flush with in_valid while FULL of memwrite entries
    flush = 1;
    drive(1, 0, 64'd50, 5'b00100);
    tick();
    flush = 0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_ctrl", out_ctrl, 0);
    chk("flush_occ", occupancy, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_keeps_cnt", stall_cnt, 7);
    drive(0, 1, 64'd0, 5'b0);
    tick();
    chk("flush_dropped", out_valid, 0);
    drive(1, 1, 64'd60, 5'b01010);
    tick();
    chk("post_flush_alu", out_data[133:70], 60);
    chk("post_flush_ctrl", out_ctrl, 5'b01010);

    // Flush together with consume from FULL
    drive(1, 0, 64'd61, 5'b00100);
    tick();
    flush = 1;
    drive(0, 1, 64'd0, 5'b0);
    tick();
    flush = 0;
    chk("flush_consume_occ", occupancy, 0);

    // Mixed handshake pattern, model-checked each cycle
    for (int i = 0; i < 48; i++) begin
      flush = (i == 17 || i == 33);
      drive((i % 3) != 0, (i % 4) != 1, 64'(200 + i), CW'(i));
      tick();
    end
    flush = 0;
    drive(0, 1, 64'd0, 5'b0);
    tick(); tick(); tick();
    chk("final_occ", occupancy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
